fetch_seq_ctrl: RTL and testbench
=================================

Name: fetch_seq_ctrl

Overview:
- Owns the architectural PC register and sequences instruction fetch for the single-issue MIPS core.
- Issues one instruction-memory request at a time and presents the fetched word to decode with a valid/stall handshake.
- Takes the next PC from the sequential path (pc+4) or from the redirect inputs, which the npc unit drives for taken branches and jumps. Redirects squash any fetch in flight.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1
- imem_ack  in  1  memory has accepted the request and returned data this cycle
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- stall  in  1  decode cannot accept the presented instruction this cycle
- redirect  in  1  taken branch/jump; pulse of 1 cycle
- redirect_pc  in  32  redirect target from the npc unit; bits [1:0] forced to 0 internally
- inst_valid  out  1  inst/inst_pc hold a live instruction
- inst  out  32  fetched instruction
- inst_pc  out  32  address of inst

Behaviour:
- Reset (rst=1 at a clock edge):
  - state<=IDLE, pc<=RESET_PC, pend<=0.
  - imem_req, inst_valid, inst, inst_pc all 0.
  - Overrides everything, including a fetch in flight; an imem_ack in IDLE is ignored.
- States:
  - IDLE: imem_req=0. Always goes to REQ next cycle (one bubble after reset).
  - REQ:
    - imem_req=1, imem_addr=pc.
    - On imem_ack with no squash: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, go to HOLD.
    - With no ack: stay in REQ. Address stays held.
  - HOLD:
    - inst_valid=1, imem_req=0.
    - Consume means inst_valid&&!stall. On consume: pc<=pc+4, inst_valid<=0, go to REQ.
    - Otherwise hold all outputs.
- Throughput: a zero-wait memory (ack in the same cycle as req) and no stall give one instruction per 2 cycles. Each extra wait cycle adds one.
- Redirect priority: redirect beats sequential advance and beats stall.
  - In HOLD: pc<=redirect_pc, inst_valid<=0, go to REQ. The held instruction is dropped even if it is stalled.
  - In REQ with imem_ack in the same cycle: discard rdata, pc<=redirect_pc, stay in REQ.
  - In REQ without ack: keep imem_addr=old pc until ack (the memory contract requires a stable address).
    - Latch pend<=1 and pend_pc<=redirect_pc.
    - On that ack: discard rdata, pc<=pend_pc, pend<=0, re-issue.
  - A second redirect while pend=1 overwrites pend_pc; the last one wins.
  - In IDLE: pc<=redirect_pc.
- Arithmetic: pc+4 is 32-bit modulo, so 0xFFFF_FFFC wraps to 0x0000_0000. redirect_pc[1:0] are ignored.
- Invariant: imem_req and inst_valid are never both 1.

Optional Feature:
- FETCH_PERF_CNT_EN
  - Defined: adds outputs fetch_cnt[31:0] (increments on each accepted, non-discarded ack) and squash_cnt[31:0] (increments on each discarded ack and each dropped HOLD instruction).
    - Both clear on rst and wrap modulo 2^32.
  - Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package mips_fetch_pkg:
  - state encoding IDLE=2'd0, REQ=2'd1, HOLD=2'd2
  - constant RESET_PC_DEFAULT
  - constant PC_INC=32'd4
- No sub-module: the sequential pc+4 adder stays inline. Branch and jump target computation stays in the existing npc unit and is not duplicated here.

Test Plan:
- Reset and zero-wait fetch:
  - Stimulus: rst for 2 cycles, then release; memory acks on the same cycle as req; stall=0.
  - Required: one idle cycle after reset, then imem_addr=0x3000.
  - Required: inst_valid pulses with inst_pc 0x3000, 0x3004, 0x3008, one every 2 cycles.
- Stall hold:
  - Stimulus: stall=1 for 3 cycles while in HOLD with inst_pc=0x3004.
  - Required: inst, inst_pc and inst_valid stay constant and imem_req=0.
  - Required: on stall release the next request is at 0x3008.
- Redirect in HOLD:
  - Stimulus: redirect=1 with redirect_pc=0x0000_4010 while inst_pc=0x3008 and stall=1.
  - Required: next cycle inst_valid=0; next request at 0x4010.
- Redirect during a 3-cycle memory wait:
  - Stimulus: request at 0x300C; redirect to 0x5000 on wait cycle 1.
  - Required: imem_addr stays 0x300C until ack; that data is not presented; next request at 0x5000.
- Wrap and alignment:
  - Stimulus: redirect_pc=0xFFFF_FFFF.
  - Required: fetch at 0xFFFF_FFFC, then 0x0000_0000.
- Reset mid-fetch:
  - Stimulus: rst asserted while in REQ awaiting ack; ack arrives on the reset cycle.
  - Required: inst_valid stays 0; fetch restarts at 0x3000.
  - Required under FETCH_PERF_CNT_EN: counters read 0.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - fetch sequencer state encoding and PC constants
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] PC_INC           = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_seq_ctrl.sv
// rtl/fetch_seq_ctrl.sv - PC owner and one-at-a-time instruction fetch sequencer
// FETCH_PERF_CNT_EN adds fetch_cnt/squash_cnt outputs.
module fetch_seq_ctrl
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] squash_cnt
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         pend_q, pend_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic         valid_q, valid_d;
    logic [31:0]  target_pc;

    assign target_pc = word_align(redirect_pc);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= 32'd0;
            inst_q    <= 32'd0;
            inst_pc_q <= 32'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;

        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect) begin
                    pc_d = target_pc;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        // Same-cycle redirect is newer than any pending one.
                        pc_d   = target_pc;
                        pend_d = 1'b0;
                    end else if (pend_q) begin
                        pc_d   = pend_pc_q;
                        pend_d = 1'b0;
                    end else begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                        state_d   = HOLD;
                    end
                end else if (redirect) begin
                    // Memory still owns the old address; park the target until ack.
                    pend_d    = 1'b1;
                    pend_pc_d = target_pc;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = target_pc;
                    valid_d = 1'b0;
                    state_d = REQ;
                end else if (valid_q && !stall) begin
                    pc_d    = pc_q + PC_INC;
                    valid_d = 1'b0;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign imem_req   = (state_q == REQ);
    assign imem_addr  = pc_q;
    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic fetch_hit;
    logic squash_hit;

    assign fetch_hit  = (state_q == REQ) && imem_ack && !redirect && !pend_q;
    assign squash_hit = ((state_q == REQ) && imem_ack && (redirect || pend_q))
                     || ((state_q == HOLD) && redirect);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt  <= 32'd0;
            squash_cnt <= 32'd0;
        end else begin
            if (fetch_hit) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (squash_hit) begin
                squash_cnt <= squash_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb/tb_fetch_seq_ctrl.sv - scoreboard bench for fetch_seq_ctrl
module tb_fetch_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] squash_cnt;
`endif

    fetch_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .squash_cnt  (squash_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_wait = 0;
    bit force_ack = 0;
    bit mon_en = 0;

    logic [31:0] exp_req_q[$];
    logic [63:0] exp_inst_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pres(input logic [31:0] pc, input int budget);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (inst_valid && inst_pc == pc) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_pres actual=timeout required=inst_pc %h", pc);
        end
    endtask

    task automatic push_fetch(input logic [31:0] pc, input logic [31:0] word);
        exp_req_q.push_back(pc);
        exp_inst_q.push_back({pc, word});
    endtask

    // Instruction memory: acks after mem_wait extra cycles, data is ~address.
    initial begin
        int cnt;
        cnt = 0;
        imem_ack = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #2;
            if (force_ack) begin
                imem_ack = 1'b1;
                imem_rdata = ~imem_addr;
                cnt = 0;
            end else if (imem_req) begin
                if (cnt >= mem_wait) begin
                    imem_ack = 1'b1;
                    imem_rdata = ~imem_addr;
                    cnt = 0;
                end else begin
                    imem_ack = 1'b0;
                    imem_rdata = 32'hDEAD_BEEF;
                    cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
                cnt = 0;
            end
        end
    end

    // Monitor: pops expected requests and presentations as the DUT shows them.
    initial begin
        logic        req_prev;
        logic        ack_prev;
        logic        valid_prev;
        logic [31:0] addr_prev;
        logic [63:0] e;
        req_prev = 1'b0;
        ack_prev = 1'b0;
        valid_prev = 1'b0;
        addr_prev = 32'd0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("req_valid_exclusive", {31'd0, imem_req & inst_valid}, 32'd0);
                if (imem_req && (!req_prev || ack_prev)) begin
                    if (exp_req_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req actual=%h required=none", imem_addr);
                    end else begin
                        chk("req_addr", imem_addr, exp_req_q.pop_front());
                    end
                end else if (imem_req && req_prev) begin
                    chk("addr_stable", imem_addr, addr_prev);
                end
                if (inst_valid && !valid_prev) begin
                    if (exp_inst_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_inst actual=%h required=none", inst_pc);
                    end else begin
                        e = exp_inst_q.pop_front();
                        chk("inst_pc", inst_pc, e[63:32]);
                        chk("inst", inst, e[31:0]);
                    end
                end
                req_prev = imem_req;
                ack_prev = imem_ack;
                addr_prev = imem_addr;
                valid_prev = inst_valid;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int c1;
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'd0;

        // Reset and zero-wait fetch
        tick();
        mon_en = 1;
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        tick();
        push_fetch(32'h0000_3000, 32'hFFFF_CFFF);
        push_fetch(32'h0000_3004, 32'hFFFF_CFFB);
        push_fetch(32'h0000_3008, 32'hFFFF_CFF7);
        rst = 1'b0;
        chk("idle_bubble_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0000_3000);
        wait_pres(32'h0000_3000, 10);
        c0 = cyc;
        wait_pres(32'h0000_3004, 10);
        c1 = cyc;
        chk("issue_gap", 32'(c1 - c0), 32'd2);

        // Stall hold on 0x3004
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("stall_inst_pc", inst_pc, 32'h0000_3004);
            chk("stall_inst", inst, 32'hFFFF_CFFB);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("after_stall_addr", imem_addr, 32'h0000_3008);

        // Redirect in HOLD while stalled
        wait_pres(32'h0000_3008, 10);
        push_fetch(32'h0000_4010, 32'hFFFF_BFEF);
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_4010;
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        chk("hold_redir_valid", {31'd0, inst_valid}, 32'd0);
        chk("hold_redir_addr", imem_addr, 32'h0000_4010);

        // Redirect during a 3-cycle memory wait
        wait_pres(32'h0000_4010, 10);
        exp_req_q.push_back(32'h0000_300C);
        mem_wait = 3;
        redirect = 1'b1;
        redirect_pc = 32'h0000_300C;
        tick();
        chk("wait_req_addr", imem_addr, 32'h0000_300C);
        push_fetch(32'h0000_5000, 32'hFFFF_AFFF);
        redirect_pc = 32'h0000_5000;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("wait_addr_held", imem_addr, 32'h0000_300C);
            tick();
        end
        chk("wait_addr_held", imem_addr, 32'h0000_300C);
        tick();
        chk("pend_reissue_addr", imem_addr, 32'h0000_5000);
        chk("pend_no_present", {31'd0, inst_valid}, 32'd0);

        // Wrap and alignment
        wait_pres(32'h0000_5000, 20);
        push_fetch(32'hFFFF_FFFC, 32'h0000_0003);
        push_fetch(32'h0000_0000, 32'hFFFF_FFFF);
        mem_wait = 0;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        chk("align_addr", imem_addr, 32'hFFFF_FFFC);
        wait_pres(32'hFFFF_FFFC, 10);
        wait_pres(32'h0000_0000, 10);

        // Reset mid-fetch with ack on the reset cycle
        exp_req_q.push_back(32'h0000_0004);
        mem_wait = 100;
        tick();
        chk("pre_rst_addr", imem_addr, 32'h0000_0004);
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt, 32'd7);
        chk("squash_cnt", squash_cnt, 32'd4);
`endif
        tick();
        rst = 1'b1;
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        chk("midrst_valid", {31'd0, inst_valid}, 32'd0);
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_inst", inst, 32'd0);
        chk("midrst_inst_pc", inst_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_fetch_cnt", fetch_cnt, 32'd0);
        chk("rst_squash_cnt", squash_cnt, 32'd0);
`endif
        tick();
        push_fetch(32'h0000_3000, 32'hFFFF_CFFF);
        mem_wait = 0;
        rst = 1'b0;
        chk("midrst_valid_bubble", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("restart_addr", imem_addr, 32'h0000_3000);
        wait_pres(32'h0000_3000, 10);
        stall = 1'b1;
        tick();
        tick();
        chk("req_queue_empty", 32'(exp_req_q.size()), 32'd0);
        chk("inst_queue_empty", 32'(exp_inst_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
